// File: rtl/axi4_sram_responder_pkg.sv
// Shared AXI4 encodings, FSM state types and burst address helpers for the SRAM responder.
package axi4_sram_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    // A burst is usable when size fits the 64-bit bus, the type is not reserved,
    // and a WRAP burst has a power-of-two beat count of 2..16.
    function automatic logic burst_legal(logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        logic ok;
        ok = (size <= 3'd3) && (burst != BURST_RSVD);
        if (burst == BURST_WRAP)
            ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return ok;
    endfunction

    // Address of the next beat; arithmetic is 32-bit modulo.
    function automatic logic [31:0] axi4_next_addr(logic [31:0] addr, logic [7:0] len,
                                                   logic [2:0] size, logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] nxt;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_INCR: nxt = addr + step;
            BURST_WRAP: nxt = (addr & ~mask) | ((addr + step) & mask);
            default:    nxt = addr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi4_sram_responder_if.sv
// AXI4 bus bundle between a master and the SRAM responder.
interface axi4_sram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                    in_arready;
    logic                    in_arvalid;
    logic [ID_WIDTH-1:0]     in_arid;
    logic [ADDR_WIDTH-1:0]   in_araddr;
    logic [7:0]              in_arlen;
    logic [2:0]              in_arsize;
    logic [1:0]              in_arburst;
    logic                    in_rready;
    logic                    in_rvalid;
    logic [ID_WIDTH-1:0]     in_rid;
    logic [DATA_WIDTH-1:0]   in_rdata;
    logic [1:0]              in_rresp;
    logic                    in_rlast;
    logic                    in_awready;
    logic                    in_awvalid;
    logic [ID_WIDTH-1:0]     in_awid;
    logic [ADDR_WIDTH-1:0]   in_awaddr;
    logic [7:0]              in_awlen;
    logic [2:0]              in_awsize;
    logic [1:0]              in_awburst;
    logic                    in_wready;
    logic                    in_wvalid;
    logic [DATA_WIDTH-1:0]   in_wdata;
    logic [DATA_WIDTH/8-1:0] in_wstrb;
    logic                    in_wlast;
    logic                    in_bready;
    logic                    in_bvalid;
    logic [ID_WIDTH-1:0]     in_bid;
    logic [1:0]              in_bresp;

    modport slave (
        output in_arready, in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
               in_awready, in_wready, in_bvalid, in_bid, in_bresp,
        input  in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst, in_rready,
               in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
               in_wvalid, in_wdata, in_wstrb, in_wlast, in_bready
    );

    modport master (
        input  in_arready, in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
               in_awready, in_wready, in_bvalid, in_bid, in_bresp,
        output in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst, in_rready,
               in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
               in_wvalid, in_wdata, in_wstrb, in_wlast, in_bready
    );
endinterface

// File: rtl/axi4_sram_responder_array.sv
// 1R1W word-wide SRAM with byte-enable writes and a combinational read port.
// A read of the word being written in the same cycle returns the old contents.
module axi4_sram_responder_array #(
    parameter int MEM_AW     = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [MEM_AW-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [MEM_AW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    // Byte-enabled write; storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 slave terminating in on-chip SRAM: independent read/write FSMs, one
// transaction each, programmable first-beat read latency.
module axi4_sram_responder #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 64,
    parameter int          ID_WIDTH   = 4,
    parameter int          MEM_AW     = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    axi4_sram_responder_if.slave bus
);
    import axi4_sram_responder_pkg::*;

    localparam logic [31:0] SRAM_BYTES = 32'd8 << MEM_AW;
    localparam logic [7:0]  LAT_LOAD   = 8'(RD_LATENCY - 1);

    rd_state_e             r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_beat, r_lat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [31:0]           r_off;
    logic                  ar_hs, r_hs, r_last_beat, r_ok;

    wr_state_e             w_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [31:0]           w_off;
    logic                  aw_hs, w_hs, w_last_beat, w_ok, w_bad, w_err, mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign ar_hs       = bus.in_arvalid && (r_state == R_IDLE);
    assign r_hs        = bus.in_rready && (r_state == R_DATA);
    assign r_last_beat = (r_beat == r_len);
    assign r_off       = r_addr - BASE_ADDR;
    assign r_ok        = burst_legal(r_len, r_size, r_burst) && (r_off < SRAM_BYTES);

    assign aw_hs       = bus.in_awvalid && (w_state == W_IDLE);
    assign w_hs        = bus.in_wvalid && (w_state == W_DATA);
    assign w_last_beat = (w_beat == w_len);
    assign w_off       = w_addr - BASE_ADDR;
    assign w_ok        = burst_legal(w_len, w_size, w_burst) && (w_off < SRAM_BYTES);
    // A beat errs on a bad address/burst or when wlast disagrees with the beat count.
    assign w_bad       = !w_ok || (bus.in_wlast != w_last_beat);
    assign mem_we      = w_hs && w_ok;

    // Read state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Read next-state: wait out the latency, then stream beats without gaps.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_WAIT;
            R_WAIT:  if (r_lat == 8'd0) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read channel outputs; everything but arready is zero outside R_DATA.
    always_comb begin
        bus.in_arready = (r_state == R_IDLE);
        bus.in_rvalid  = 1'b0;
        bus.in_rid     = '0;
        bus.in_rdata   = '0;
        bus.in_rresp   = RESP_OKAY;
        bus.in_rlast   = 1'b0;
        if (r_state == R_DATA) begin
            bus.in_rvalid = 1'b1;
            bus.in_rid    = r_id;
            bus.in_rdata  = r_ok ? mem_rdata : '0;
            bus.in_rresp  = r_ok ? RESP_OKAY : RESP_SLVERR;
            bus.in_rlast  = r_last_beat;
        end
    end

    // Read latency countdown and beat counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lat  <= 8'd0;
            r_beat <= 8'd0;
        end else if (ar_hs) begin
            r_lat  <= LAT_LOAD;
            r_beat <= 8'd0;
        end else begin
            if ((r_state == R_WAIT) && (r_lat != 8'd0)) r_lat <= r_lat - 8'd1;
            if (r_hs) r_beat <= r_beat + 8'd1;
        end
    end

    // Capture the read request; the address advances on each accepted beat.
    always_ff @(posedge clock) begin
        if (ar_hs) begin
            r_id    <= bus.in_arid;
            r_addr  <= bus.in_araddr;
            r_len   <= bus.in_arlen;
            r_size  <= bus.in_arsize;
            r_burst <= bus.in_arburst;
        end else if (r_hs) begin
            r_addr  <= axi4_next_addr(r_addr, r_len, r_size, r_burst);
        end
    end

    // Write state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Write next-state: the burst ends on wlast or the final counted beat.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && (bus.in_wlast || w_last_beat)) w_state_nxt = W_RESP;
            W_RESP:  if (bus.in_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write channel outputs; W beats are stalled until an address is accepted.
    always_comb begin
        bus.in_awready = (w_state == W_IDLE);
        bus.in_wready  = (w_state == W_DATA);
        bus.in_bvalid  = 1'b0;
        bus.in_bid     = '0;
        bus.in_bresp   = RESP_OKAY;
        if (w_state == W_RESP) begin
            bus.in_bvalid = 1'b1;
            bus.in_bid    = w_id;
            bus.in_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Write beat counter and sticky burst error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_beat <= 8'd0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_beat <= 8'd0;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err | w_bad;
        end
    end

    // Capture the write request; the address advances on each accepted beat.
    always_ff @(posedge clock) begin
        if (aw_hs) begin
            w_id    <= bus.in_awid;
            w_addr  <= bus.in_awaddr;
            w_len   <= bus.in_awlen;
            w_size  <= bus.in_awsize;
            w_burst <= bus.in_awburst;
        end else if (w_hs) begin
            w_addr  <= axi4_next_addr(w_addr, w_len, w_size, w_burst);
        end
    end

    axi4_sram_responder_array #(
        .MEM_AW     (MEM_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (w_off[MEM_AW+2:3]),
        .wdata (bus.in_wdata),
        .wstrb (bus.in_wstrb),
        .raddr (r_off[MEM_AW+2:3]),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_axi4_sram_responder.sv
// Scoreboard bench for axi4_sram_responder: expected read beats are queued
// from a byte-level memory model when each request is issued.
module tb_axi4_sram_responder;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi4_sram_responder_if bus();

    axi4_sram_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [63:0] wdat_q[$];
    logic [7:0]  wstb_q[$];
    logic [63:0] model [int];
    int          tests_run = 0;
    int          fails = 0;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_put(logic [31:0] a, logic [63:0] d, logic [7:0] s);
        int k;
        logic [63:0] w;
        if (!((a >= 32'h8000_0000) && (a < 32'h8000_8000))) return;
        k = int'((a - 32'h8000_0000) >> 3);
        w = model.exists(k) ? model[k] : 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model[k] = w;
    endfunction

    function automatic logic [63:0] model_get(int k);
        return model.exists(k) ? model[k] : 64'hx;
    endfunction

    // Issue one read burst and record every accepted beat in obs_q.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle,
                           output int lat, output int gaps);
        int guard;
        bit phase;
        bit done;
        bus.in_arvalid = 1'b1;
        bus.in_arid    = id;
        bus.in_araddr  = addr;
        bus.in_arlen   = len;
        bus.in_arsize  = size;
        bus.in_arburst = burst;
        guard = 0;
        while (!bus.in_arready && guard < 200) begin tick(); guard++; end
        tick();
        bus.in_arvalid = 1'b0;
        lat = 0;
        while (!bus.in_rvalid && lat < 200) begin tick(); lat++; end
        gaps = 0; phase = 1'b1; done = 1'b0; guard = 0;
        while (!done && guard < 1000) begin
            bus.in_rready = toggle ? phase : 1'b1;
            if (!bus.in_rvalid) gaps++;
            else if (bus.in_rready) begin
                obs_q.push_back({bus.in_rdata, bus.in_rresp, bus.in_rlast, bus.in_rid});
                if (bus.in_rlast) done = 1'b1;
            end
            tick();
            phase = ~phase;
            guard++;
        end
        bus.in_rready = 1'b0;
    endtask

    // Issue one write burst of nbeats from wdat_q/wstb_q; optionally hold bready low.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                            input int hold_b, output logic [1:0] bresp, output logic [3:0] bid,
                            output int stall_bad);
        int guard;
        bus.in_awvalid = 1'b1;
        bus.in_awid    = id;
        bus.in_awaddr  = addr;
        bus.in_awlen   = len;
        bus.in_awsize  = size;
        bus.in_awburst = burst;
        guard = 0;
        while (!bus.in_awready && guard < 200) begin tick(); guard++; end
        tick();
        bus.in_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.in_wvalid = 1'b1;
            bus.in_wdata  = wdat_q[i];
            bus.in_wstrb  = wstb_q[i];
            bus.in_wlast  = (i == nbeats - 1);
            guard = 0;
            while (!bus.in_wready && guard < 200) begin tick(); guard++; end
            tick();
        end
        bus.in_wvalid = 1'b0;
        bus.in_wlast  = 1'b0;
        guard = 0;
        while (!bus.in_bvalid && guard < 200) begin tick(); guard++; end
        stall_bad = 0;
        for (int i = 0; i < hold_b; i++) begin
            if (!bus.in_bvalid || (bus.in_bid !== id) || (bus.in_awready !== 1'b0)) stall_bad++;
            tick();
        end
        bresp = bus.in_bvalid ? bus.in_bresp : 2'bxx;
        bid   = bus.in_bvalid ? bus.in_bid : 4'bxxxx;
        bus.in_bready = 1'b1;
        tick();
        bus.in_bready = 1'b0;
        wdat_q.delete();
        wstb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_arvalid = 0; bus.in_arid = 0; bus.in_araddr = 0; bus.in_arlen = 0;
        bus.in_arsize = 0; bus.in_arburst = 0; bus.in_rready = 0;
        bus.in_awvalid = 0; bus.in_awid = 0; bus.in_awaddr = 0; bus.in_awlen = 0;
        bus.in_awsize = 0; bus.in_awburst = 0;
        bus.in_wvalid = 0; bus.in_wdata = 0; bus.in_wstrb = 0; bus.in_wlast = 0; bus.in_bready = 0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.in_arready !== 1'b1) begin fails++; $display("FAIL reset_arready got %b want 1", bus.in_arready); end
        tests_run++;
        if (bus.in_awready !== 1'b1) begin fails++; $display("FAIL reset_awready got %b want 1", bus.in_awready); end
        tests_run++;
        if ({bus.in_rvalid, bus.in_wready, bus.in_bvalid, bus.in_rlast} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs got rvalid=%b wready=%b bvalid=%b rlast=%b want 0",
                     bus.in_rvalid, bus.in_wready, bus.in_bvalid, bus.in_rlast);
        end
    endtask

    task automatic test_single_read();
        logic [1:0] br; logic [3:0] bi; int sb, lat, gaps; beat_t e, o;
        wdat_q.push_back(64'h1122334455667788); wstb_q.push_back(8'hFF);
        model_put(32'h8000_0010, 64'h1122334455667788, 8'hFF);
        do_write(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'h3, 1, 0, br, bi, sb);
        tests_run++;
        if ({br, bi} !== {2'b00, 4'h3}) begin fails++; $display("FAIL single_write_b got resp=%b id=%h want 00/3", br, bi); end
        exp_q.push_back({model_get(2), 2'b00, 1'b1, 4'h5});
        do_read(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'h5, 1'b0, lat, gaps);
        tests_run++;
        if (lat !== 4) begin fails++; $display("FAIL single_read_latency got %0d want 4", lat); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL single_read_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_incr_write();
        logic [1:0] br; logic [3:0] bi; int sb, lat, gaps, n; beat_t e, o;
        logic [7:0] strb_new [4];
        strb_new = '{8'hFF, 8'hFF, 8'h0F, 8'hFF};
        bus.in_wvalid = 1'b1; bus.in_wdata = 64'hDEAD; bus.in_wstrb = 8'hFF;
        tick(); tick();
        tests_run++;
        if (bus.in_wready !== 1'b0) begin fails++; $display("FAIL w_before_aw_wready got %b want 0", bus.in_wready); end
        bus.in_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdat_q.push_back({32'hCAFE_0000 + i, 32'h1234_0000 + i}); wstb_q.push_back(8'hFF);
            model_put(32'h8000_0100 + 8*i, {32'hCAFE_0000 + i, 32'h1234_0000 + i}, 8'hFF);
        end
        do_write(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'hA, 4, 0, br, bi, sb);
        tests_run++;
        if ({br, bi} !== {2'b00, 4'hA}) begin fails++; $display("FAIL incr_write1_b got resp=%b id=%h want 00/a", br, bi); end
        for (int i = 0; i < 4; i++) begin
            wdat_q.push_back({32'hB1B1_B100 + i, 32'h5555_0000 + i}); wstb_q.push_back(strb_new[i]);
            model_put(32'h8000_0100 + 8*i, {32'hB1B1_B100 + i, 32'h5555_0000 + i}, strb_new[i]);
        end
        do_write(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'hB, 4, 0, br, bi, sb);
        tests_run++;
        if ({br, bi} !== {2'b00, 4'hB}) begin fails++; $display("FAIL incr_write2_b got resp=%b id=%h want 00/b", br, bi); end
        for (int i = 0; i < 4; i++) exp_q.push_back({model_get(32 + i), 2'b00, (i == 3), 4'h6});
        do_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h6, 1'b0, lat, gaps);
        tests_run++;
        n = obs_q.size();
        if (n < 3 || obs_q[2].data !== 64'hCAFE_0002_5555_0002) begin
            fails++; $display("FAIL incr_write_partial got beats=%0d want word2 cafe00025555000_2 upper kept", n);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL incr_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL incr_read_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap_read();
        logic [1:0] br; logic [3:0] bi; int sb, lat, gaps; beat_t e, o;
        int order [4];
        order = '{3, 0, 1, 2};
        for (int i = 0; i < 4; i++) begin
            wdat_q.push_back(64'h5A5A_0000_0000_00D0 + i); wstb_q.push_back(8'hFF);
            model_put(32'h8000_0000 + 8*i, 64'h5A5A_0000_0000_00D0 + i, 8'hFF);
        end
        do_write(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h1, 4, 0, br, bi, sb);
        tests_run++;
        if (br !== 2'b00) begin fails++; $display("FAIL wrap_fill_b got %b want 00", br); end
        for (int j = 0; j < 4; j++) exp_q.push_back({model_get(order[j]), 2'b00, (j == 3), 4'h9});
        do_read(32'h8000_0018, 8'd3, 3'd3, 2'b10, 4'h9, 1'b0, lat, gaps);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL wrap_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL wrap_read_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_out_of_range();
        logic [1:0] br; logic [3:0] bi; int sb, lat, gaps; beat_t e, o;
        exp_q.push_back({64'h0, 2'b10, 1'b1, 4'h4});
        do_read(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0, lat, gaps);
        wdat_q.push_back(64'hE0E0_E0E0_E0E0_E0E0); wstb_q.push_back(8'hFF);
        wdat_q.push_back(64'hE1E1_E1E1_E1E1_E1E1); wstb_q.push_back(8'hFF);
        model_put(32'h8000_7FF8, 64'hE0E0_E0E0_E0E0_E0E0, 8'hFF);
        model_put(32'h8000_8000, 64'hE1E1_E1E1_E1E1_E1E1, 8'hFF);
        do_write(32'h8000_7FF8, 8'd1, 3'd3, 2'b01, 4'h2, 2, 0, br, bi, sb);
        tests_run++;
        if ({br, bi} !== {2'b10, 4'h2}) begin fails++; $display("FAIL oor_write_b got resp=%b id=%h want 10/2", br, bi); end
        exp_q.push_back({model_get(4095), 2'b00, 1'b1, 4'h4});
        do_read(32'h8000_7FF8, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0, lat, gaps);
        for (int i = 0; i < 3; i++) exp_q.push_back({64'h0, 2'b10, (i == 2), 4'hD});
        do_read(32'h8000_0000, 8'd2, 3'd3, 2'b10, 4'hD, 1'b0, lat, gaps);
        wdat_q.push_back(64'hF0F0_0000_0000_0000); wstb_q.push_back(8'hFF);
        wdat_q.push_back(64'hF1F1_0000_0000_0001); wstb_q.push_back(8'hFF);
        model_put(32'h8000_0200, 64'hF0F0_0000_0000_0000, 8'hFF);
        model_put(32'h8000_0208, 64'hF1F1_0000_0000_0001, 8'hFF);
        do_write(32'h8000_0200, 8'd3, 3'd3, 2'b01, 4'hE, 2, 0, br, bi, sb);
        tests_run++;
        if ({br, bi} !== {2'b10, 4'hE}) begin fails++; $display("FAIL early_wlast_b got resp=%b id=%h want 10/e", br, bi); end
        tests_run++;
        if (bus.in_awready !== 1'b1) begin fails++; $display("FAIL early_wlast_idle got awready=%b want 1", bus.in_awready); end
        for (int i = 0; i < 2; i++) exp_q.push_back({model_get(64 + i), 2'b00, (i == 1), 4'h8});
        do_read(32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'h8, 1'b0, lat, gaps);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL oor_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL oor_read_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [1:0] br; logic [3:0] bi; int sb, lat, gaps; beat_t e, o;
        for (int i = 0; i < 4; i++) exp_q.push_back({model_get(32 + i), 2'b00, (i == 3), 4'hF});
        do_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'hF, 1'b1, lat, gaps);
        tests_run++;
        if (gaps !== 0) begin fails++; $display("FAIL bp_rvalid_gaps got %0d want 0", gaps); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL bp_read_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        wdat_q.push_back(64'h0BAD_F00D_0000_0300); wstb_q.push_back(8'hFF);
        model_put(32'h8000_0300, 64'h0BAD_F00D_0000_0300, 8'hFF);
        do_write(32'h8000_0300, 8'd0, 3'd3, 2'b01, 4'hC, 1, 10, br, bi, sb);
        tests_run++;
        if (sb !== 0) begin fails++; $display("FAIL bp_b_stall got %0d bad cycles want 0", sb); end
        tests_run++;
        if ({br, bi} !== {2'b00, 4'hC}) begin fails++; $display("FAIL bp_write_b got resp=%b id=%h want 00/c", br, bi); end
    endtask

    task automatic test_reset_mid_burst();
        int guard, lat, gaps; beat_t e, o;
        bus.in_awvalid = 1'b1; bus.in_awid = 4'h7; bus.in_awaddr = 32'h8000_0400;
        bus.in_awlen = 8'd3; bus.in_awsize = 3'd3; bus.in_awburst = 2'b01;
        guard = 0;
        while (!bus.in_awready && guard < 200) begin tick(); guard++; end
        tick();
        bus.in_awvalid = 1'b0;
        bus.in_arvalid = 1'b1; bus.in_arid = 4'h2; bus.in_araddr = 32'h8000_0000;
        bus.in_arlen = 8'd3; bus.in_arsize = 3'd3; bus.in_arburst = 2'b01;
        guard = 0;
        while (!bus.in_arready && guard < 200) begin tick(); guard++; end
        tick();
        bus.in_arvalid = 1'b0;
        guard = 0;
        while (!bus.in_rvalid && guard < 200) begin tick(); guard++; end
        bus.in_rready = 1'b1;
        tick(); tick();
        tests_run++;
        if ({bus.in_rvalid, bus.in_wready} !== 2'b11) begin
            fails++; $display("FAIL mid_burst_pre got rvalid=%b wready=%b want 1/1", bus.in_rvalid, bus.in_wready);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_rvalid, bus.in_bvalid, bus.in_wready} !== 3'b000) begin
            fails++; $display("FAIL mid_burst_reset got rvalid=%b bvalid=%b wready=%b want 0",
                              bus.in_rvalid, bus.in_bvalid, bus.in_wready);
        end
        bus.in_rready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({bus.in_arready, bus.in_awready} !== 2'b11) begin
            fails++; $display("FAIL mid_burst_release got arready=%b awready=%b want 1/1", bus.in_arready, bus.in_awready);
        end
        exp_q.push_back({model_get(1), 2'b00, 1'b1, 4'h6});
        do_read(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h6, 1'b0, lat, gaps);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL post_reset_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin fails++; $display("FAIL post_reset_beat got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_incr_write();
        test_wrap_read();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
